// File: rtl/byte_addr_fetch_if.sv
// Bundle of the request/response handshake and the block-RAM read port.
// The slave side is the fetch adapter; the master side is the datapath plus the memory.
interface byte_addr_fetch_if #(
  parameter int IDX_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             mem_en;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_rdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [31:0]      rsp_addr;
  logic [1:0]       rsp_err;

  modport slave (
    input  req_valid, req_addr, mem_rdata, rsp_ready,
    output req_ready, mem_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport master (
    output req_valid, req_addr, mem_rdata, rsp_ready,
    input  req_ready, mem_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/byte_addr_fetch.sv
// Byte-address to word-index read adapter: checks alignment and range, issues one
// synchronous memory read and holds the word in a response slot until it is consumed.
module byte_addr_fetch #(
  parameter int IDX_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  byte_addr_fetch_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             mem_en_q, mem_en_d;
  logic [IDX_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [31:0]      rsp_addr_q, rsp_addr_d;
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic misaligned;
  logic out_of_range;
  logic req_ready;
  logic accept;

  // Upper bits beyond the word index are checked rather than silently wrapped.
  assign misaligned   = |bus.req_addr[1:0];
  assign out_of_range = |bus.req_addr[31:IDX_W+2];
  assign req_ready    = (state_q == IDLE) && !flush;
  assign accept       = req_ready && bus.req_valid;

  always_comb begin
    state_d    = state_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_addr_d = bus.req_addr;
          if (misaligned || out_of_range) begin
            rsp_err_d  = {out_of_range, misaligned};
            rsp_data_d = 32'h0;
            state_d    = RESP;
          end else begin
            mem_addr_d = bus.req_addr[IDX_W+1:2];
            mem_en_d   = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = bus.mem_rdata;
        rsp_err_d  = 2'b00;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over both handshakes; the response slot contents are simply abandoned.
    if (flush) begin
      state_d  = IDLE;
      mem_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rsp_data_q <= 32'h0;
      rsp_addr_q <= 32'h0;
      rsp_err_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_byte_addr_fetch.sv
// Bench for byte_addr_fetch: transaction-level model checked every cycle, plus
// directed transactions with hand-computed results.
module tb_byte_addr_fetch;
  localparam int IDX_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  byte_addr_fetch_if #(.IDX_W(IDX_W)) bus ();

  byte_addr_fetch #(.IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] mem_arr [0:(1<<IDX_W)-1];

  // Synchronous word memory: data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, response due a fixed number of
  // edges after the accepting edge (0 for rejected requests, 2 for memory reads).
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  int          m_resp_at = 0;
  logic [1:0]  m_err = 2'b00;
  logic [31:0] m_addr = 0;
  logic [31:0] m_idx = 0;
  logic [31:0] m_data = 0;

  always @(posedge clk or negedge rst_n) begin
    bit consumed;
    bit old_busy;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      consumed = m_busy && (cyc >= m_resp_at) && bus.rsp_ready;
      old_busy = m_busy;
      cyc++;
      if (flush) begin
        m_busy = 1'b0;
      end else if (consumed) begin
        m_busy = 1'b0;
      end else if (!old_busy && bus.req_valid) begin
        m_busy    = 1'b1;
        m_acc     = cyc;
        m_addr    = bus.req_addr;
        m_err     = {((bus.req_addr >> (IDX_W + 2)) != 0), ((bus.req_addr % 4) != 0)};
        m_idx     = bus.req_addr / 4;
        m_data    = (m_err != 2'b00) ? 32'h0 : mem_arr[m_idx[IDX_W-1:0]];
        m_resp_at = m_acc + ((m_err != 2'b00) ? 0 : 2);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_rv;
    bit exp_en;
    if (mon_en && rst_n) begin
      exp_rv = m_busy && (cyc >= m_resp_at);
      exp_en = m_busy && (m_err == 2'b00) && (cyc == m_acc);
      chk("mdl_req_ready", bus.req_ready, !m_busy && !flush);
      chk("mdl_mem_en", bus.mem_en, exp_en);
      if (exp_en) chk("mdl_mem_addr", bus.mem_addr, m_idx);
      chk("mdl_rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("mdl_rsp_data", bus.rsp_data, m_data);
        chk("mdl_rsp_addr", bus.rsp_addr, m_addr);
        chk("mdl_rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_addr", bus.rsp_addr, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 1);
  endtask

  // One request from idle; lat = edges after the accepting edge before rsp_valid is seen.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_err, input int exp_lat, input logic [31:0] exp_idx);
    int lat = -1;
    int n_en = 0;
    logic [31:0] seen_idx = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        n_en++;
        seen_idx = {22'h0, bus.mem_addr};
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("txn_latency", lat, exp_lat);
    chk("txn_mem_en_cycles", n_en, (exp_err == 2'b00) ? 1 : 0);
    if (exp_err == 2'b00) chk("txn_mem_addr", seen_idx, exp_idx);
    chk("txn_rsp_data", bus.rsp_data, exp_data);
    chk("txn_rsp_err", bus.rsp_err, exp_err);
    chk("txn_rsp_addr", bus.rsp_addr, addr);
    $display("txn addr=%h data=%h err=%b latency=%0d", addr, bus.rsp_data, bus.rsp_err, lat);
    if (bus.rsp_ready) begin
      tick();
      chk("txn_ready_after_consume", bus.req_ready, 1);
    end
  endtask

  // Flush raised 'stage' edges after the accept (0=ISSUE, 1=CAPTURE, 2=RESP).
  task automatic flush_at(input int stage);
    bus.rsp_ready = (stage < 2);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    tick();
    bus.req_valid = 1'b0;
    repeat (stage) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rsp_valid_before", bus.rsp_valid, (stage == 2));
    chk("flush_req_ready_masked", bus.req_ready, 0);
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_rsp_valid_after", bus.rsp_valid, 0);
      chk("flush_mem_en_after", bus.mem_en, 0);
      chk("flush_idle", bus.req_ready, 1);
    end
    tick();
    $display("txn flush stage=%0d", stage);
    bus.rsp_ready = 1'b1;
    do_req(32'h8, 32'h1234_5678, 2'b00, 2, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < (1 << IDX_W); i++) mem_arr[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
    mem_arr[2]    = 32'h1234_5678;
    mem_arr[4]    = 32'hDEAD_BEEF;
    mem_arr[1023] = 32'hCAFE_F00D;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b1;

    #1 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    do_req(32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 2, 4);
    do_req(32'h0000_0012, 32'h0, 2'b01, 0, 0);
    do_req(32'h0000_1000, 32'h0, 2'b10, 0, 0);
    do_req(32'hFFFF_FFFF, 32'h0, 2'b11, 0, 0);
    do_req(32'h0000_0FFC, 32'hCAFE_F00D, 2'b00, 2, 1023);
    do_req(32'h0000_1000, 32'h0, 2'b10, 0, 0);

    // Continuous valid requests: one accept every 4 cycles.
    cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.mem_en) cnt++;
    end
    tick();
    bus.req_valid = 1'b0;
    chk("period_valid_reads", cnt, 2);
    $display("txn back-to-back valid reads=%0d", cnt);

    // Continuous rejected requests: one response every 2 cycles.
    cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h12;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) cnt++;
    end
    tick();
    bus.req_valid = 1'b0;
    chk("period_error_reqs", cnt, 3);
    $display("txn back-to-back error responses=%0d", cnt);

    // Backpressure: response held, new requests ignored.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    tick();
    bus.req_valid = 1'b0;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_rsp_valid_seen", bus.rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h20;
      @(negedge clk);
      chk("bp_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
      chk("bp_rsp_addr", bus.rsp_addr, 32'h10);
      chk("bp_rsp_err", bus.rsp_err, 0);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", bus.req_ready, 1);
    chk("bp_release_rsp_valid", bus.rsp_valid, 0);
    $display("txn backpressure addr=00000010 held 5 cycles");

    flush_at(0);
    flush_at(1);
    flush_at(2);

    // Flush in idle blocks a simultaneous request.
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_mem_en", bus.mem_en, 0);
    chk("flush_idle_no_rsp", bus.rsp_valid, 0);
    tick();
    $display("txn flush in idle with req_valid");

    // Asynchronous reset during CAPTURE.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    tick();
    bus.req_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    tick();
    rst_n = 1'b1;
    $display("txn reset during capture");
    do_req(32'h8, 32'h1234_5678, 2'b00, 2, 2);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
